// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter stage.
// Width defaults, FSM state encoding and word-addressing constants.
package pc_pkg;

  localparam int PC_WIDTH_DEFAULT        = 32;
  localparam int OFFSET_WIDTH_DEFAULT    = 8;
  localparam int STALL_CNT_WIDTH_DEFAULT = 16;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Offsets count instructions; shifting by two turns them into byte offsets.
  localparam int WORD_SHIFT = 2;

  localparam int SEXT_FILL_DEFAULT = PC_WIDTH_DEFAULT - OFFSET_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } pc_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Branch/jump target: PC+4 plus the sign-extended instruction offset in bytes.
// Kept standalone so the pipelined core can reuse it in its execute stage.
module branch_target_adder
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEFAULT
) (
  input  logic [PC_WIDTH-1:0]     i_pc_plus4,
  input  logic [OFFSET_WIDTH-1:0] i_offset,
  output logic [PC_WIDTH-1:0]     o_target
);

  localparam int SEXT_FILL = PC_WIDTH - OFFSET_WIDTH;

  logic [PC_WIDTH-1:0] w_offset_sext;
  logic [PC_WIDTH-1:0] w_offset_bytes;

  assign w_offset_sext  = {{SEXT_FILL{i_offset[OFFSET_WIDTH-1]}}, i_offset};
  assign w_offset_bytes = w_offset_sext << WORD_SHIFT;

  // Wraps modulo 2^PC_WIDTH; there is deliberately no overflow indication.
  assign o_target = i_pc_plus4 + w_offset_bytes;

endmodule

// File: rtl/pc_unit.sv
// Program-counter register stage: selects sequential/branch/jump next PC,
// holds it across memory busy-waits and reports fetch-valid/redirect status.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH        = PC_WIDTH_DEFAULT,
  parameter int                  OFFSET_WIDTH    = OFFSET_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int                  STALL_CNT_WIDTH = STALL_CNT_WIDTH_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [PC_WIDTH-1:0]        PC_PLUS4,
  input  logic                       JUMP,
  input  logic                       BRANCH,
  input  logic                       ZERO,
  input  logic [OFFSET_WIDTH-1:0]    OFFSET,
  input  logic                       BUSYWAIT,
  output logic [PC_WIDTH-1:0]        PC,
  output logic                       INSTR_VALID,
  output logic                       REDIRECT,
  output logic [STALL_CNT_WIDTH-1:0] STALL_COUNT
);

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  pc_state_e                  r_state;
  logic [PC_WIDTH-1:0]        r_pc;
  logic                       r_instr_valid;
  logic                       r_redirect;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  pc_state_e                  w_state_nxt;
  logic [PC_WIDTH-1:0]        w_pc_nxt;
  logic                       w_instr_valid_nxt;
  logic                       w_redirect_nxt;
  logic                       w_stall_inc;
  logic [STALL_CNT_WIDTH-1:0] w_stall_cnt_nxt;

  logic [PC_WIDTH-1:0]        w_pc_plus4_al;
  logic [PC_WIDTH-1:0]        w_target;
  logic [PC_WIDTH-1:0]        w_next_pc;
  logic                       w_taken;
  logic                       w_unused_pc_lsbs;

  // The adder's low bits are meaningless here: the PC is always word aligned.
  assign w_pc_plus4_al    = {PC_PLUS4[PC_WIDTH-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};
  assign w_unused_pc_lsbs = &{1'b0, PC_PLUS4[WORD_SHIFT-1:0]};

  branch_target_adder #(
    .PC_WIDTH     (PC_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_branch_target_adder (
    .i_pc_plus4 (w_pc_plus4_al),
    .i_offset   (OFFSET),
    .o_target   (w_target)
  );

  assign w_taken   = JUMP | (BRANCH & ZERO);
  assign w_next_pc = w_taken ? w_target : w_pc_plus4_al;

  // Next-state, next-PC and status decode for the BOOT/RUN/STALL sequencer.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_redirect_nxt    = r_redirect;
    w_stall_inc       = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt       = ST_RUN;
        w_instr_valid_nxt = 1'b1;
        w_redirect_nxt    = 1'b0;
      end
      ST_RUN: begin
        if (BUSYWAIT) begin
          w_state_nxt       = ST_STALL;
          w_instr_valid_nxt = 1'b0;
          w_redirect_nxt    = 1'b0;
          w_stall_inc       = 1'b1;
        end else begin
          w_pc_nxt          = w_next_pc;
          w_instr_valid_nxt = 1'b1;
          w_redirect_nxt    = w_taken;
        end
      end
      ST_STALL: begin
        // The stalled instruction is still presented, so its branch decision
        // is taken from the cycle the stall lifts.
        if (BUSYWAIT) begin
          w_instr_valid_nxt = 1'b0;
          w_redirect_nxt    = 1'b0;
          w_stall_inc       = 1'b1;
        end else begin
          w_state_nxt       = ST_RUN;
          w_pc_nxt          = w_next_pc;
          w_instr_valid_nxt = 1'b1;
          w_redirect_nxt    = w_taken;
        end
      end
      default: begin
        w_state_nxt       = ST_BOOT;
        w_pc_nxt          = RESET_PC;
        w_instr_valid_nxt = 1'b0;
        w_redirect_nxt    = 1'b0;
      end
    endcase
  end

  // Saturating stall-cycle counter increment.
  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
    end else begin
      w_stall_cnt_nxt = r_stall_cnt;
    end
  end

  // State, PC, status and counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_redirect    <= 1'b0;
      r_stall_cnt   <= {STALL_CNT_WIDTH{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_redirect    <= w_redirect_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
    end
  end

  assign PC          = r_pc;
  assign INSTR_VALID = r_instr_valid;
  assign REDIRECT    = r_redirect;
  assign STALL_COUNT = r_stall_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC_PLUS4;
  logic        JUMP, BRANCH, ZERO, BUSYWAIT;
  logic [7:0]  OFFSET;
  logic [31:0] PC;
  logic        INSTR_VALID, REDIRECT;
  logic [15:0] STALL_COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: "booting" flag, PC, status, stall total
  logic [31:0] m_pc;
  bit          m_boot, m_valid, m_redirect;
  int          m_stalls;

  pc_unit dut (
    .CLK(CLK), .RESET(RESET), .PC_PLUS4(PC_PLUS4), .JUMP(JUMP), .BRANCH(BRANCH),
    .ZERO(ZERO), .OFFSET(OFFSET), .BUSYWAIT(BUSYWAIT), .PC(PC),
    .INSTR_VALID(INSTR_VALID), .REDIRECT(REDIRECT), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_boot = 1'b1; m_valid = 1'b0; m_redirect = 1'b0; m_stalls = 0;
  endtask

  // One rising edge of the reference: boot cycle, hold on busywait, else advance.
  task automatic model_edge();
    logic [31:0] base;
    int          off;
    bit          tk;
    if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1; m_redirect = 1'b0;
    end else if (BUSYWAIT) begin
      m_valid = 1'b0; m_redirect = 1'b0;
      if (m_stalls < 65535) m_stalls++;
    end else begin
      base = PC_PLUS4 & 32'hFFFF_FFFC;
      off  = int'($signed(OFFSET));
      tk   = JUMP || (BRANCH && ZERO);
      m_pc = tk ? base + 32'(off * 4) : base;
      m_redirect = tk; m_valid = 1'b1;
    end
  endtask

  task automatic check_all();
    check_eq("pc", PC, m_pc);
    check_eq("instr_valid", {31'b0, INSTR_VALID}, {31'b0, m_valid});
    check_eq("redirect", {31'b0, REDIRECT}, {31'b0, m_redirect});
    check_eq("stall_count", {16'b0, STALL_COUNT}, 32'(m_stalls));
  endtask

  task automatic drive(input bit j, input bit b, input bit z, input logic [7:0] off, input bit bw);
    JUMP = j; BRANCH = b; ZERO = z; OFFSET = off; BUSYWAIT = bw;
    PC_PLUS4 = m_pc + 32'd4;
  endtask

  task automatic step();
    @(posedge CLK);
    if (RESET) model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 RESET = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    RESET = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge CLK);
    check_all();
    RESET = 1'b1;

    // boot holds PC for one edge, then sequential fetch
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check_eq("boot_pc", PC, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      step();
      check_eq("seq_pc", PC, 32'(4 * i));
    end

    // taken branch backwards, then untaken branch
    drive(1'b0, 1'b1, 1'b1, 8'hFE, 1'b0); step();
    check_eq("beq_taken_pc", PC, 32'h0C);
    check_eq("beq_taken_redir", {31'b0, REDIRECT}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); step();
    check_eq("redir_one_cycle", {31'b0, REDIRECT}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 8'hFE, 1'b0); step();
    check_eq("beq_untaken_pc", PC, 32'h14);

    // jumps, simultaneous jump+branch
    drive(1'b1, 1'b0, 1'b0, 8'h02, 1'b0); step();
    check_eq("jump_pc_20", PC, 32'h20);
    drive(1'b1, 1'b1, 1'b1, 8'h03, 1'b0); step();
    check_eq("jump_pc_30", PC, 32'h30);

    // wrap-around: sequential and negative offset
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); PC_PLUS4 = 32'hFFFF_FFFC; step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); step();
    check_eq("wrap_seq", PC, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0); PC_PLUS4 = 32'h0; step();
    check_eq("wrap_neg_off", PC, 32'hFFFF_FFFC);

    // five-cycle stall at 0x40
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); PC_PLUS4 = 32'h40; step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
      check_eq("stall_hold_pc", PC, 32'h40);
      check_eq("stall_valid", {31'b0, INSTR_VALID}, 32'h0);
    end
    check_eq("stall_count5", {16'b0, STALL_COUNT}, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); step();
    check_eq("stall_release_pc", PC, 32'h44);
    check_eq("stall_release_valid", {31'b0, INSTR_VALID}, 32'h1);

    // branch held through a stall, taken as busywait falls
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); PC_PLUS4 = 32'h40; step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 8'h02, 1'b1); step();
      check_eq("stall_br_hold", PC, 32'h40);
    end
    drive(1'b0, 1'b1, 1'b1, 8'h02, 1'b0); step();
    check_eq("stall_br_pc", PC, 32'h4C);
    check_eq("stall_br_redir", {31'b0, REDIRECT}, 32'h1);

    // asynchronous reset mid-stall, then BOOT ignores busywait
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
    async_reset_pulse();
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_stall_count", {16'b0, STALL_COUNT}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
    check_eq("reboot_valid", {31'b0, INSTR_VALID}, 32'h1);
    check_eq("reboot_pc", PC, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(7) == 0), ($urandom_range(3) == 0), 1'($urandom_range(1)),
            8'($urandom), ($urandom_range(3) == 0));
      r = PC_PLUS4;
      if ($urandom_range(15) == 0) r = $urandom;
      else r[1:0] = 2'($urandom_range(3));
      PC_PLUS4 = r;
      step();
      if ($urandom_range(99) == 0) async_reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter register stage of the 8-bit single-cycle processor.
- Sits directly downstream of the PC adder: consumes its PC+4 result, selects the next PC (sequential / branch / jump) and registers it.
- Holds the PC while the instruction or data memory asserts BUSYWAIT.
- Drives the instruction-memory address, the PC adder input, and a fetch-valid/redirect status pair.

Parameters:
- PC_WIDTH, 32, width of PC and all address arithmetic.
- OFFSET_WIDTH, 8, width of the signed branch/jump offset field (instruction count).
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- STALL_CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- PC_PLUS4  input  PC_WIDTH  incremented PC from the PC adder.
- JUMP  input  1  unconditional jump, from control unit.
- BRANCH  input  1  branch-if-equal instruction, from control unit.
- ZERO  input  1  ALU zero flag.
- OFFSET  input  OFFSET_WIDTH  signed instruction offset (instruction[23:16]).
- BUSYWAIT  input  1  memory stall request (instruction OR data memory).
- PC  output  PC_WIDTH  current program counter.
- INSTR_VALID  output  1  registered; 1 = the instruction at PC is being executed this cycle.
- REDIRECT  output  1  registered; 1 for the cycle after a taken branch or jump.
- STALL_COUNT  output  STALL_CNT_WIDTH  stall cycles since reset, saturating.

Behaviour:
- Reset (RESET=0, asynchronous, takes effect immediately, including mid-stall):
  - PC=RESET_PC, state=BOOT, INSTR_VALID=0, REDIRECT=0, STALL_COUNT=0.
  - Inputs are ignored while RESET=0.
- next_pc (combinational):
  - target = PC_PLUS4 + (sign_extend(OFFSET) << 2), modulo 2^PC_WIDTH.
  - taken = JUMP | (BRANCH & ZERO).
  - next_pc = taken ? target : PC_PLUS4.
  - PC_PLUS4[1:0] is ignored (treated as 00); PC[1:0] is always 00.
- State machine (BOOT, RUN, STALL), evaluated on rising CLK:
  - BOOT: PC held for one cycle so memory sees a stable address. Next state is RUN; INSTR_VALID<=1. BUSYWAIT is ignored in BOOT.
  - RUN, BUSYWAIT=0: PC<=next_pc; REDIRECT<=taken; INSTR_VALID stays 1.
  - RUN, BUSYWAIT=1: PC held; next state STALL; INSTR_VALID<=0; REDIRECT<=0; STALL_COUNT increments.
  - STALL, BUSYWAIT=1: PC held; STALL_COUNT increments each cycle.
  - STALL, BUSYWAIT=0: PC<=next_pc using inputs of that cycle (the instruction is unchanged while stalled); REDIRECT<=taken; INSTR_VALID<=1; next state RUN.
- Latency: exactly one edge from a non-stalled cycle to the new PC. No extra bubble after a redirect.
- Arithmetic: all additions wrap modulo 2^PC_WIDTH with no overflow flag. Example: PC_PLUS4=0 with OFFSET=-1 gives target 0xFFFFFFFC.
- Simultaneous JUMP and BRANCH: the result is taken; both produce the same target.
- BRANCH with ZERO=0: sequential (PC_PLUS4).
- STALL_COUNT saturates at all-ones and is cleared only by reset.
- BUSYWAIT falling and a taken branch in the same cycle: PC goes to target, REDIRECT=1.
- Reset released coincident with a CLK edge: reset dominates that edge; BOOT lasts through the next edge.

Decomposition:
- Shared package pc_pkg:
  - state encoding: BOOT=2'd0, RUN=2'd1, STALL=2'd2.
  - RESET_PC default.
  - WORD_SHIFT=2 constant.
  - sign-extension width constants.
- One sub-module is natural: branch_target_adder (PC_PLUS4 + shifted, sign-extended OFFSET), kept separate so it can be reused in the pipelined version.
- The FSM, PC register and counter stay in pc_unit.

Test Plan:
- Reset then release, PC_PLUS4 driven as PC+4, no control → PC = 0 for two edges (BOOT, then first RUN cycle), then 4, 8, 12. INSTR_VALID=0 during BOOT, 1 afterwards.
- PC=0x10, BRANCH=1, ZERO=1, OFFSET=8'hFE → PC=0x0C next edge, REDIRECT=1 for one cycle. Repeat with ZERO=0 → PC=0x14, REDIRECT=0.
- PC=0x20, JUMP=1, OFFSET=8'h03 → PC=0x30. At PC=0xFFFFFFFC with PC_PLUS4=0 and no control → PC wraps to 0.
- BUSYWAIT high for 5 cycles in RUN at PC=0x40:
  - PC holds 0x40 and INSTR_VALID=0 throughout.
  - STALL_COUNT=5.
  - On release, PC=0x44 and INSTR_VALID=1.
- Stall with BRANCH=1, ZERO=1, OFFSET=8'h02 held while stalled at PC=0x40 → on release PC=0x4C, REDIRECT=1, with no early update during the stall.
- RESET pulsed low asynchronously mid-stall (between edges) → PC=RESET_PC, STALL_COUNT=0, INSTR_VALID=0 immediately. The BOOT sequence then repeats.
